// File: rtl/icache_ro_if.sv
// ---------------------------------------------------------------------------
// icache_ro_if
//
// Groups the two buses around the read-only instruction cache into one
// bundle: the fetch side (instruction read from the PC stage) and the
// memory side (256-bit cacheline reads from physical memory).
//
// Signals:
//   mem_read      fetch request from the datapath
//   mem_address   byte address of the instruction (bits [1:0] ignored)
//   mem_rdata     instruction word, zero unless mem_resp is high
//   mem_resp      request satisfied this cycle
//   pmem_read     cacheline read request to memory
//   pmem_address  line-aligned address {tag, index, 5'b0}
//   pmem_rdata    fill line, word w in bits [32w+31:32w]
//   pmem_resp     single-cycle pulse, pmem_rdata valid in the same cycle
//
// Modports:
//   slave   the cache itself (serves fetches, issues line reads)
//   master  the surrounding system (datapath plus memory model)
// ---------------------------------------------------------------------------
interface icache_ro_if;
  logic         mem_read;
  logic [31:0]  mem_address;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic         pmem_read;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  modport slave (
    input  mem_read,
    input  mem_address,
    output mem_rdata,
    output mem_resp,
    output pmem_read,
    output pmem_address,
    input  pmem_rdata,
    input  pmem_resp
  );

  modport master (
    output mem_read,
    output mem_address,
    input  mem_rdata,
    input  mem_resp,
    input  pmem_read,
    input  pmem_address,
    output pmem_rdata,
    output pmem_resp
  );
endinterface

// File: rtl/icache_ro.sv
// ---------------------------------------------------------------------------
// icache_ro
//
// Read-only, direct-mapped instruction cache. A lookup that hits answers in
// the same cycle as the request. A miss latches the line address, issues a
// 256-bit line read to memory, installs the returned line and then lets the
// still-pending request hit on the following LOOKUP cycle.
//
// Parameters:
//   S_INDEX     number of index bits (2**S_INDEX sets). Offset is fixed at
//               5 bits (32-byte line); the tag is the remaining 27-S_INDEX.
//
// Ports:
//   clk         system clock, all state updates on the rising edge
//   rst         asynchronous, active-high reset
//   bus         icache_ro_if.slave, fetch side and memory side
//   hit_count   number of cycles with mem_resp=1 (wraps at 2^32)
//   miss_count  number of misses started (wraps at 2^32)
// ---------------------------------------------------------------------------
module icache_ro #(
  parameter int S_INDEX = 4
) (
  input  logic        clk,
  input  logic        rst,
  icache_ro_if.slave  bus,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int SETS  = 1 << S_INDEX;
  localparam int TAG_W = 27 - S_INDEX;

  typedef enum logic {
    LOOKUP = 1'b0,
    MISS   = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Per-set storage. Only the valid bits are reset; tags and data are
  // qualified by valid and so can start out unknown.
  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [255:0]     data_q [SETS];

  // Line being fetched; held for the whole MISS state so that changes on
  // the fetch side cannot redirect an in-flight fill.
  logic [TAG_W-1:0]   miss_tag_q,   miss_tag_d;
  logic [S_INDEX-1:0] miss_index_q, miss_index_d;

  logic [31:0] hit_cnt_q,  hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Request address split.
  logic [2:0]         req_word;
  logic [S_INDEX-1:0] req_index;
  logic [TAG_W-1:0]   req_tag;

  assign req_word  = bus.mem_address[4:2];
  assign req_index = bus.mem_address[S_INDEX+4:5];
  assign req_tag   = bus.mem_address[31:S_INDEX+5];

  logic hit;
  logic miss_start;
  logic fill;

  assign hit        = bus.mem_read && valid_q[req_index] &&
                      (tag_q[req_index] == req_tag) && (state_q == LOOKUP);
  assign miss_start = bus.mem_read && !hit && (state_q == LOOKUP);
  // A pmem_resp outside MISS (including one trailing a reset) is dropped.
  assign fill       = (state_q == MISS) && bus.pmem_resp;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOOKUP;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOOKUP: if (miss_start) state_d = MISS;
      MISS:   if (bus.pmem_resp) state_d = LOOKUP;
      default: state_d = LOOKUP;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // pmem_read and pmem_address depend only on registered state so the
  // memory side sees a glitch-free, stable request for the whole miss.
  // -------------------------------------------------------------------------
  always_comb begin
    bus.mem_resp     = 1'b0;
    bus.mem_rdata    = 32'h0;
    bus.pmem_read    = 1'b0;
    bus.pmem_address = 32'h0;
    unique case (state_q)
      LOOKUP: begin
        if (hit) begin
          bus.mem_resp  = 1'b1;
          bus.mem_rdata = data_q[req_index][{req_word, 5'b00000} +: 32];
        end
      end
      MISS: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = {miss_tag_q, miss_index_q, 5'b00000};
      end
      default: begin
        bus.mem_resp = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Miss address latch and performance counters
  // -------------------------------------------------------------------------
  always_comb begin
    miss_tag_d   = miss_tag_q;
    miss_index_d = miss_index_q;
    if (miss_start) begin
      miss_tag_d   = req_tag;
      miss_index_d = req_index;
    end
  end

  // Counters wrap naturally through 32-bit addition.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit)        hit_cnt_d  = hit_cnt_q + 32'd1;
    if (miss_start) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_tag_q   <= '0;
      miss_index_q <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      miss_tag_q   <= miss_tag_d;
      miss_index_q <= miss_index_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  // -------------------------------------------------------------------------
  // Line storage: valid bits (reset) and tag/data arrays (not reset)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill) begin
      valid_q[miss_index_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[miss_index_q]  <= miss_tag_q;
      data_q[miss_index_q] <= bus.pmem_rdata;
    end
  end

endmodule

// File: tb/tb_icache_ro.sv
module tb_icache_ro;

  logic        clk;
  logic        rst;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int tests_run;
  int tests_failed;

  icache_ro_if bus();

  icache_ro #(.S_INDEX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line whose word w is base + w.
  function automatic logic [255:0] mkline(input logic [31:0] base);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = base + w;
    return l;
  endfunction

  // Advance to just after the next rising edge; inputs are driven here and
  // outputs are sampled on the following falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: called at cycle 0 of a miss (request already driven),
  // pulses pmem_resp in cycle L and returns in cycle L+1.
  task automatic serve_fill(input logic [31:0] base, input int lat);
    for (int c = 1; c <= lat; c++) begin
      step();
      if (c == lat) begin
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = mkline(base);
      end
    end
    step();
    bus.pmem_resp = 1'b0;
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    bus.mem_read    = 1'b0;
    bus.mem_address = 32'h0;
    bus.pmem_resp   = 1'b0;
    bus.pmem_rdata  = '0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.mem_resp !== 1'b0 || bus.mem_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_resp: resp=%b rdata=%h expected 0/0", bus.mem_resp, bus.mem_rdata);
    end
    tests_run++;
    if (bus.pmem_read !== 1'b0 || bus.pmem_address !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_pmem: read=%b addr=%h expected 0/0", bus.pmem_read, bus.pmem_address);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.mem_resp !== 1'b0 || bus.pmem_read !== 1'b0 ||
          hit_count !== 32'd0 || miss_count !== 32'd0) begin
        tests_failed++;
        $display("FAIL idle_%0d: resp=%b pread=%b hits=%0d misses=%0d expected all 0",
                 i, bus.mem_resp, bus.pmem_read, hit_count, miss_count);
      end
      step();
    end
  endtask

  task automatic test_cold_miss();
    bus.mem_read    = 1'b1;
    bus.mem_address = 32'h0000_006C;
    @(negedge clk);
    tests_run++;
    if (bus.mem_resp !== 1'b0 || bus.pmem_read !== 1'b0) begin
      tests_failed++;
      $display("FAIL cold_c0: resp=%b pread=%b expected 0/0", bus.mem_resp, bus.pmem_read);
    end
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 3) begin
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = mkline(32'hA000_0000);
      end
      @(negedge clk);
      tests_run++;
      if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h0000_0060 || bus.mem_resp !== 1'b0) begin
        tests_failed++;
        $display("FAIL cold_c%0d: pread=%b paddr=%h resp=%b expected 1/00000060/0",
                 c, bus.pmem_read, bus.pmem_address, bus.mem_resp);
      end
    end
    step();
    bus.pmem_resp = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.mem_resp !== 1'b1 || bus.mem_rdata !== 32'hA000_0003 || bus.pmem_read !== 1'b0) begin
      tests_failed++;
      $display("FAIL cold_c4: resp=%b rdata=%h pread=%b expected 1/a0000003/0",
               bus.mem_resp, bus.mem_rdata, bus.pmem_read);
    end
    step();
    bus.mem_read = 1'b0;
    @(negedge clk);
    tests_run++;
    if (hit_count !== 32'd1 || miss_count !== 32'd1) begin
      tests_failed++;
      $display("FAIL cold_counts: hits=%0d misses=%0d expected 1/1", hit_count, miss_count);
    end
  endtask

  task automatic test_hit_same_line();
    step();
    bus.mem_read    = 1'b1;
    bus.mem_address = 32'h0000_007C;
    @(negedge clk);
    tests_run++;
    if (bus.mem_resp !== 1'b1 || bus.mem_rdata !== 32'hA000_0007 || bus.pmem_read !== 1'b0) begin
      tests_failed++;
      $display("FAIL hit_line: resp=%b rdata=%h pread=%b expected 1/a0000007/0",
               bus.mem_resp, bus.mem_rdata, bus.pmem_read);
    end
    step();
    bus.mem_read = 1'b0;
    @(negedge clk);
    tests_run++;
    if (hit_count !== 32'd2 || bus.mem_resp !== 1'b0 || bus.mem_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL hit_after: hits=%0d resp=%b rdata=%h expected 2/0/0",
               hit_count, bus.mem_resp, bus.mem_rdata);
    end
  endtask

  task automatic test_conflict();
    step();
    bus.mem_read    = 1'b1;
    bus.mem_address = 32'h0000_0260;
    @(negedge clk);
    tests_run++;
    if (bus.mem_resp !== 1'b0) begin
      tests_failed++;
      $display("FAIL conflict_miss: resp=%b expected 0", bus.mem_resp);
    end
    step();
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = mkline(32'hB000_0000);
    @(negedge clk);
    tests_run++;
    if (bus.pmem_address !== 32'h0000_0260 || bus.pmem_read !== 1'b1) begin
      tests_failed++;
      $display("FAIL conflict_paddr: paddr=%h pread=%b expected 00000260/1", bus.pmem_address, bus.pmem_read);
    end
    step();
    bus.pmem_resp = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.mem_resp !== 1'b1 || bus.mem_rdata !== 32'hB000_0000) begin
      tests_failed++;
      $display("FAIL conflict_hit: resp=%b rdata=%h expected 1/b0000000", bus.mem_resp, bus.mem_rdata);
    end
    step();
    bus.mem_address = 32'h0000_0060;
    @(negedge clk);
    tests_run++;
    if (bus.mem_resp !== 1'b0) begin
      tests_failed++;
      $display("FAIL evicted_miss: resp=%b expected 0", bus.mem_resp);
    end
    serve_fill(32'hA000_0000, 2);
    @(negedge clk);
    tests_run++;
    if (bus.mem_resp !== 1'b1 || bus.mem_rdata !== 32'hA000_0000) begin
      tests_failed++;
      $display("FAIL refill_hit: resp=%b rdata=%h expected 1/a0000000", bus.mem_resp, bus.mem_rdata);
    end
    step();
    bus.mem_read = 1'b0;
    @(negedge clk);
    tests_run++;
    if (miss_count !== 32'd3 || hit_count !== 32'd4) begin
      tests_failed++;
      $display("FAIL conflict_counts: misses=%0d hits=%0d expected 3/4", miss_count, hit_count);
    end
  endtask

  task automatic test_addr_change();
    step();
    bus.mem_read    = 1'b1;
    bus.mem_address = 32'h0000_0100;
    step();
    @(negedge clk);
    tests_run++;
    if (bus.pmem_address !== 32'h0000_0100) begin
      tests_failed++;
      $display("FAIL chg_c1: paddr=%h expected 00000100", bus.pmem_address);
    end
    step();
    bus.mem_address = 32'h0000_0400;
    @(negedge clk);
    tests_run++;
    if (bus.pmem_address !== 32'h0000_0100 || bus.pmem_read !== 1'b1 || bus.mem_resp !== 1'b0) begin
      tests_failed++;
      $display("FAIL chg_c2: paddr=%h pread=%b resp=%b expected 00000100/1/0",
               bus.pmem_address, bus.pmem_read, bus.mem_resp);
    end
    step();
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = mkline(32'hC000_0000);
    @(negedge clk);
    tests_run++;
    if (bus.pmem_address !== 32'h0000_0100) begin
      tests_failed++;
      $display("FAIL chg_c3: paddr=%h expected 00000100", bus.pmem_address);
    end
    step();
    bus.pmem_resp = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.mem_resp !== 1'b0) begin
      tests_failed++;
      $display("FAIL chg_newmiss: resp=%b expected 0", bus.mem_resp);
    end
    step();
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = mkline(32'hD000_0000);
    @(negedge clk);
    tests_run++;
    if (bus.pmem_address !== 32'h0000_0400 || bus.pmem_read !== 1'b1) begin
      tests_failed++;
      $display("FAIL chg_paddr2: paddr=%h pread=%b expected 00000400/1", bus.pmem_address, bus.pmem_read);
    end
    step();
    bus.pmem_resp = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.mem_resp !== 1'b1 || bus.mem_rdata !== 32'hD000_0000) begin
      tests_failed++;
      $display("FAIL chg_hit400: resp=%b rdata=%h expected 1/d0000000", bus.mem_resp, bus.mem_rdata);
    end
    step();
    bus.mem_address = 32'h0000_0108;
    @(negedge clk);
    tests_run++;
    if (bus.mem_resp !== 1'b1 || bus.mem_rdata !== 32'hC000_0002) begin
      tests_failed++;
      $display("FAIL chg_hit100: resp=%b rdata=%h expected 1/c0000002", bus.mem_resp, bus.mem_rdata);
    end
    step();
    bus.mem_read = 1'b0;
    @(negedge clk);
    tests_run++;
    if (miss_count !== 32'd5 || hit_count !== 32'd6) begin
      tests_failed++;
      $display("FAIL chg_counts: misses=%0d hits=%0d expected 5/6", miss_count, hit_count);
    end
  endtask

  task automatic test_reset_mid_miss();
    step();
    bus.mem_read    = 1'b1;
    bus.mem_address = 32'h0000_00A0;
    step();
    step();
    @(negedge clk);
    tests_run++;
    if (bus.pmem_read !== 1'b1) begin
      tests_failed++;
      $display("FAIL rmid_pre: pread=%b expected 1", bus.pmem_read);
    end
    // Mid-cycle, away from any rising edge.
    #1;
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.pmem_read !== 1'b0 || bus.pmem_address !== 32'h0 ||
        hit_count !== 32'd0 || miss_count !== 32'd0) begin
      tests_failed++;
      $display("FAIL rmid_async: pread=%b paddr=%h hits=%0d misses=%0d expected 0/0/0/0",
               bus.pmem_read, bus.pmem_address, hit_count, miss_count);
    end
    step();
    rst            = 1'b0;
    bus.mem_read   = 1'b0;
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = mkline(32'hE000_0000);
    step();
    bus.pmem_resp   = 1'b0;
    bus.mem_read    = 1'b1;
    bus.mem_address = 32'h0000_00A0;
    @(negedge clk);
    tests_run++;
    if (bus.mem_resp !== 1'b0 || bus.pmem_read !== 1'b0) begin
      tests_failed++;
      $display("FAIL rmid_late_ignored: resp=%b pread=%b expected 0/0", bus.mem_resp, bus.pmem_read);
    end
    serve_fill(32'hF000_0000, 1);
    @(negedge clk);
    tests_run++;
    if (bus.mem_resp !== 1'b1 || bus.mem_rdata !== 32'hF000_0000) begin
      tests_failed++;
      $display("FAIL rmid_refill: resp=%b rdata=%h expected 1/f0000000", bus.mem_resp, bus.mem_rdata);
    end
    step();
    bus.mem_address = 32'h0000_0060;
    @(negedge clk);
    tests_run++;
    if (bus.mem_resp !== 1'b0) begin
      tests_failed++;
      $display("FAIL rmid_valid_cleared: resp=%b expected 0", bus.mem_resp);
    end
    step();
    bus.mem_read = 1'b0;
    @(negedge clk);
    tests_run++;
    if (miss_count !== 32'd2 || hit_count !== 32'd1 || bus.pmem_address !== 32'h0000_0060) begin
      tests_failed++;
      $display("FAIL rmid_counts: misses=%0d hits=%0d paddr=%h expected 2/1/00000060",
               miss_count, hit_count, bus.pmem_address);
    end
    serve_fill(32'hA000_0000, 1);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_cold_miss();
    test_hit_same_line();
    test_conflict();
    test_addr_change();
    test_reset_mid_miss();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/icache_ro.md
# icache_ro

Read-only, direct-mapped instruction cache between the pipeline's instruction fetch port and the shared physical memory (cacheline) bus. It serves 32-bit instruction reads from the PC stage with same-cycle hit response. On a miss it fetches one full 256-bit line and then replays the request as a hit. It also exposes hit and miss counters for performance debug.

## Interface
Parameters:
- S_INDEX, 4, number of index bits; sets = 2**S_INDEX.
- Derived, not overridable: offset = 5 bits (32-byte line), tag = 27 − S_INDEX bits.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_read  in  1  fetch request from datapath (`instr_read`).
- mem_address  in  32  byte address of instruction; bits [1:0] ignored.
- mem_rdata  out  32  instruction word; valid when mem_resp=1, else 32'h0.
- mem_resp  out  1  request satisfied this cycle.
- pmem_read  out  1  line read request to memory.
- pmem_address  out  32  line address {tag, index, 5'b0}.
- pmem_rdata  in  256  fill line; word w is bits [32w+31:32w].
- pmem_resp  in  1  one-cycle pulse; pmem_rdata valid in the same cycle.
- hit_count  out  32  number of completed hits.
- miss_count  out  32  number of misses started.

## Operation
- Storage: per set, valid bit, tag and 256-bit data. All are flops. Valid bits clear on rst; tag and data are not reset.
- Address split: offset = mem_address[4:0], word = mem_address[4:2], index = mem_address[S_INDEX+4:5], tag = mem_address[31:S_INDEX+5].
- hit = mem_read & valid[index] & (tag_arr[index] == tag) & (state == LOOKUP).
- States: LOOKUP (reset state) and MISS.
- **LOOKUP**
  - On hit: mem_resp=1 combinationally, and mem_rdata = data_arr[index] word `word`.
  - On mem_read & !hit: latch miss_tag/miss_index from mem_address, increment miss_count, and go to MISS.
  - When mem_read=0: mem_resp=0 and no state change.
- **MISS**
  - pmem_read=1 and pmem_address = {miss_tag, miss_index, 5'b0}. Both are driven from registers only.
  - mem_resp=0 for the whole state.
  - On pmem_resp: write data_arr[miss_index] = pmem_rdata, tag_arr = miss_tag, valid = 1, then go to LOOKUP.
  - Changes to mem_address or mem_read while in MISS are ignored. The fill always completes to the latched line.
- hit_count increments on every cycle with mem_resp=1. Both counters wrap modulo 2^32 without saturation.
- Replacement: a fill overwrites the resident line unconditionally. There is no dirty state and no write port.
- Reset, including mid-miss: state returns to LOOKUP, all valid bits clear, and counters go to 0. pmem_read drops immediately (asynchronous). A pmem_resp arriving after reset is ignored.
- pmem_resp while in LOOKUP is ignored.

## Timing
- Reset values:
  - mem_resp=0, mem_rdata=0.
  - pmem_read=0, pmem_address=0.
  - hit_count=0, miss_count=0.
- Hit latency: 0 cycles. Response is in the same cycle as the request, so the datapath advances on that edge.
- Miss timeline, with the request at cycle 0 and memory responding L cycles after pmem_read rises:
  - Cycle 0: miss detected, mem_resp=0.
  - Cycles 1..L: pmem_read=1; pmem_resp arrives at cycle L.
  - Cycle L+1: LOOKUP hits, mem_resp=1.
  - Total miss penalty = L+1 stall cycles.
- pmem_read is held steady until pmem_resp. pmem_address is stable throughout MISS.
- Back-to-back misses: after a fill, the LOOKUP cycle for a new missing address detects the miss, and pmem_read rises on the following cycle.

## Test plan
- Reset, then idle with mem_read=0 for 5 cycles:
  - mem_resp=0, pmem_read=0, hit_count=miss_count=0 throughout.
- Cold miss: mem_read=1, mem_address=0x0000_006C; memory returns line word w = 32'hA000_0000+w with L=3.
  - pmem_address=0x0000_0060, pmem_read high for cycles 1–3.
  - mem_resp=1 at cycle 4 with mem_rdata=32'hA000_0003.
  - miss_count=1, hit_count=1 after that edge.
- Hit in same line: after the fill, request 0x0000_007C.
  - Same-cycle mem_resp=1, mem_rdata=32'hA000_0007, pmem_read stays 0.
- Conflict eviction (S_INDEX=4): fill 0x060, then request 0x260 (same index 3, different tag).
  - Miss, pmem_address=0x0000_0260.
  - Re-requesting 0x060 misses again. miss_count=3.
- Address change during MISS: request 0x100 misses; at cycle 2 switch mem_address to 0x400.
  - pmem_address stays 0x0000_0100.
  - After the fill, 0x400 misses and then fetches 0x0000_0400.
- Reset mid-miss: assert rst in cycle 2 of a miss.
  - pmem_read falls without waiting for a clock edge.
  - A late pmem_resp is ignored.
  - The next request to the same address misses (valid bits cleared).
